// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges per-stage stall requests into stall_state, accepts EX redirects,
// discards a wrong-path fetch still in flight, and keeps saturating
// counters of stall cycles and accepted redirects.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall_req,
    input  logic             if_busy,
    input  logic             if_fetch_done,
    input  logic             id_stall_req,
    input  logic             mem_stall_req,
    input  logic             ex_jump_req,
    input  logic [31:0]      ex_jump_addr,
    output logic [5:0]       stall_state,
    output logic             jump_flag,
    output logic             pc_jump_en,
    output logic [31:0]      pc_jump_addr,
    output logic             fetch_discard,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // RUN: normal operation. KILL: a wrong-path fetch is still outstanding
    // and its returning beat must be dropped.
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] KILL = 1'b1;

    localparam logic [5:0] HOLD_TO_MEM = 6'b011111;
    localparam logic [5:0] HOLD_TO_ID  = 6'b000111;
    localparam logic [5:0] HOLD_TO_IF  = 6'b000011;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       accept;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Redirect acceptance, stall merge, flush and discard decode.
    // All outputs are forced quiet while reset is asserted.
    always_comb begin
        accept        = 1'b0;
        stall_state   = 6'b000000;
        jump_flag     = 1'b0;
        pc_jump_en    = 1'b0;
        pc_jump_addr  = 32'h0000_0000;
        fetch_discard = 1'b0;
        state_next    = state;
        if (rst) begin
            if (state == KILL) begin
                // Keep ID starved until the stale fetch has drained.
                fetch_discard = 1'b1;
                stall_state   = mem_stall_req ? HOLD_TO_MEM : HOLD_TO_IF;
                if (if_fetch_done) begin
                    state_next = RUN;
                end
            end else begin
                accept = ex_jump_req & ~mem_stall_req;
                if (accept) begin
                    // Flush overrides younger-stage stalls: their contents die anyway.
                    jump_flag     = 1'b1;
                    pc_jump_en    = 1'b1;
                    pc_jump_addr  = ex_jump_addr;
                    fetch_discard = if_fetch_done;
                    if (if_busy && !if_fetch_done) begin
                        state_next = KILL;
                    end
                end else if (mem_stall_req) begin
                    stall_state = HOLD_TO_MEM;
                end else if (id_stall_req) begin
                    stall_state = HOLD_TO_ID;
                end else if (if_stall_req) begin
                    stall_state = HOLD_TO_IF;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_state != 6'b000000) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (accept) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with a behavioural model
// compared on every falling edge, plus hand-computed literal checks.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             if_stall_req;
    logic             if_busy;
    logic             if_fetch_done;
    logic             id_stall_req;
    logic             mem_stall_req;
    logic             ex_jump_req;
    logic [31:0]      ex_jump_addr;
    logic [5:0]       stall_state;
    logic             jump_flag;
    logic             pc_jump_en;
    logic [31:0]      pc_jump_addr;
    logic             fetch_discard;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .if_busy       (if_busy),
        .if_fetch_done (if_fetch_done),
        .id_stall_req  (id_stall_req),
        .mem_stall_req (mem_stall_req),
        .ex_jump_req   (ex_jump_req),
        .ex_jump_addr  (ex_jump_addr),
        .stall_state   (stall_state),
        .jump_flag     (jump_flag),
        .pc_jump_en    (pc_jump_en),
        .pc_jump_addr  (pc_jump_addr),
        .fetch_discard (fetch_discard),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_kill: a stale fetch is outstanding after a redirect.
    bit m_kill = 1'b0;
    int m_sc   = 0;
    int m_fc   = 0;

    function automatic bit m_accept();
        return rst && ex_jump_req && !mem_stall_req && !m_kill;
    endfunction

    // Number of stages (from PC upward) that hold; the rest get bubbles/flow.
    function automatic int m_held();
        if (!rst) return 0;
        if (m_kill) return mem_stall_req ? 5 : 2;
        if (m_accept()) return 0;
        if (mem_stall_req) return 5;
        if (id_stall_req) return 3;
        if (if_stall_req) return 2;
        return 0;
    endfunction

    function automatic bit m_discard();
        if (!rst) return 1'b0;
        if (m_kill) return 1'b1;
        return m_accept() && if_fetch_done;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_kill = 1'b0;
            m_sc   = 0;
            m_fc   = 0;
        end else begin
            bit acc;
            acc = m_accept();
            if (m_held() != 0 && m_sc < CMAX) m_sc = m_sc + 1;
            if (acc && m_fc < CMAX) m_fc = m_fc + 1;
            if (m_kill) begin
                if (if_fetch_done) m_kill = 1'b0;
            end else if (acc && if_busy && !if_fetch_done) begin
                m_kill = 1'b1;
            end
        end
    end

    // Compare process: outputs are settled mid-cycle.
    always @(negedge clk) begin
        chk("stall_state", {26'd0, stall_state}, (32'd1 << m_held()) - 32'd1);
        chk("jump_flag", {31'd0, jump_flag}, {31'd0, m_accept()});
        chk("pc_jump_en", {31'd0, pc_jump_en}, {31'd0, m_accept()});
        if (m_accept()) chk("pc_jump_addr", pc_jump_addr, ex_jump_addr);
        chk("fetch_discard", {31'd0, fetch_discard}, {31'd0, m_discard()});
        chk("stall_cycles", {28'd0, stall_cycles}, m_sc);
        chk("flush_count", {28'd0, flush_count}, m_fc);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b0; if_stall_req = 0; if_busy = 0; if_fetch_done = 0;
        id_stall_req = 0; mem_stall_req = 0; ex_jump_req = 0; ex_jump_addr = 32'h0;
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("lit_reset_stall", {26'd0, stall_state}, 32'h0);
        chk("lit_reset_sc", {28'd0, stall_cycles}, 32'd0);
        chk("lit_reset_fc", {28'd0, flush_count}, 32'd0);

        // Stall priority ladder
        mem_stall_req = 1; id_stall_req = 1; #1;
        chk("lit_prio_mem", {26'd0, stall_state}, 32'h1f);
        cyc();
        mem_stall_req = 0; #1;
        chk("lit_prio_id", {26'd0, stall_state}, 32'h07);
        cyc();
        id_stall_req = 0; if_stall_req = 1; #1;
        chk("lit_prio_if", {26'd0, stall_state}, 32'h03);
        cyc();
        if_stall_req = 0;
        cyc();
        chk("lit_sc_after_prio", {28'd0, stall_cycles}, 32'd3);

        // Simple redirect, no fetch outstanding
        ex_jump_req = 1; ex_jump_addr = 32'h0000_1000; #1;
        chk("lit_jf", {31'd0, jump_flag}, 32'd1);
        chk("lit_pcen", {31'd0, pc_jump_en}, 32'd1);
        chk("lit_pcaddr", pc_jump_addr, 32'h0000_1000);
        chk("lit_jump_stall", {26'd0, stall_state}, 32'h0);
        cyc();
        ex_jump_req = 0; #1;
        chk("lit_fc_1", {28'd0, flush_count}, 32'd1);

        // Redirect with fetch outstanding -> KILL for 3 cycles
        ex_jump_req = 1; ex_jump_addr = 32'h0000_2000; if_busy = 1; #1;
        chk("lit_kill_entry_disc", {31'd0, fetch_discard}, 32'd0);
        cyc();
        ex_jump_req = 0; #1;
        chk("lit_kill1_disc", {31'd0, fetch_discard}, 32'd1);
        chk("lit_kill1_stall", {26'd0, stall_state}, 32'h03);
        cyc();
        ex_jump_req = 1; ex_jump_addr = 32'h0000_dead; #1;
        chk("lit_kill2_ignore", {31'd0, jump_flag}, 32'd0);
        cyc();
        ex_jump_req = 0; if_fetch_done = 1; #1;
        chk("lit_kill3_disc", {31'd0, fetch_discard}, 32'd1);
        cyc();
        if_fetch_done = 0; if_busy = 0; #1;
        chk("lit_back_run_disc", {31'd0, fetch_discard}, 32'd0);
        chk("lit_fc_2", {28'd0, flush_count}, 32'd2);
        chk("lit_sc_6", {28'd0, stall_cycles}, 32'd6);

        // Redirect blocked by MEM stall for 2 cycles
        ex_jump_req = 1; ex_jump_addr = 32'h0000_3000; mem_stall_req = 1; #1;
        chk("lit_blocked_jf", {31'd0, jump_flag}, 32'd0);
        chk("lit_blocked_stall", {26'd0, stall_state}, 32'h1f);
        cyc(); cyc();
        mem_stall_req = 0; #1;
        chk("lit_released_jf", {31'd0, jump_flag}, 32'd1);
        cyc();
        ex_jump_req = 0; #1;
        chk("lit_fc_3", {28'd0, flush_count}, 32'd3);

        // Accept with fetch returning the same cycle; ID stall ignored
        ex_jump_req = 1; ex_jump_addr = 32'h0000_4000; if_busy = 1; if_fetch_done = 1;
        id_stall_req = 1; #1;
        chk("lit_same_disc", {31'd0, fetch_discard}, 32'd1);
        chk("lit_same_stall", {26'd0, stall_state}, 32'h0);
        cyc();
        ex_jump_req = 0; if_busy = 0; if_fetch_done = 0; id_stall_req = 0; #1;
        chk("lit_same_stay_run", {31'd0, fetch_discard}, 32'd0);
        cyc();

        // Async reset in the middle of KILL
        ex_jump_req = 1; ex_jump_addr = 32'h0000_5000; if_busy = 1;
        cyc();
        ex_jump_req = 0; if_stall_req = 1; #1;
        chk("lit_prekill_disc", {31'd0, fetch_discard}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("lit_rst_stall", {26'd0, stall_state}, 32'h0);
        chk("lit_rst_disc", {31'd0, fetch_discard}, 32'd0);
        chk("lit_rst_sc", {28'd0, stall_cycles}, 32'd0);
        chk("lit_rst_fc", {28'd0, flush_count}, 32'd0);
        cyc(); cyc();
        if_stall_req = 0; if_busy = 0;
        rst = 1'b1;
        ex_jump_req = 1; ex_jump_addr = 32'h0000_6000; #1;
        chk("lit_rst_run_jf", {31'd0, jump_flag}, 32'd1);
        cyc();
        ex_jump_req = 0;

        // Counter saturation: 20 stalled cycles on a 4-bit counter
        id_stall_req = 1;
        for (int i = 0; i < 20; i++) cyc();
        id_stall_req = 0; #1;
        chk("lit_sat_sc", {28'd0, stall_cycles}, 32'hf);
        cyc(); cyc();
        chk("lit_sat_hold", {28'd0, stall_cycles}, 32'hf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
